// File: rtl/regfile_wr_arbiter.sv
// regfile_wr_arbiter
//   Shares one integer register-file write port between EX-stage writeback and
//   load-return data from the LSQ. EX has priority; LSQ returns are buffered in
//   a small FIFO and drained in free slots. A starvation guard forces a FIFO
//   drain (stalling EX) once the non-empty FIFO has been denied STARVE_LIMIT
//   enabled cycles in a row.
//
// Ports
//   clk_i, resetb_i, clk_en_i        : clock, sync active-low reset, clock enable
//   exs_wr_i/addr_i/data_i           : EX writeback request
//   exs_stall_o                      : EX write not taken this cycle, EX holds
//   lsq_valid_i/addr_i/data_i        : load return
//   lsq_ready_o                      : FIFO can accept a load return
//   rf_wr_o/addr_o/data_o            : registered register-file write port
//   pend_cnt_o                       : registered FIFO occupancy
module regfile_wr_arbiter #(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned FIFO_DEPTH   = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                          clk_i,
  input  logic                          resetb_i,
  input  logic                          clk_en_i,
  input  logic                          exs_wr_i,
  input  logic [4:0]                    exs_addr_i,
  input  logic [XLEN-1:0]               exs_data_i,
  output logic                          exs_stall_o,
  input  logic                          lsq_valid_i,
  output logic                          lsq_ready_o,
  input  logic [4:0]                    lsq_addr_i,
  input  logic [XLEN-1:0]               lsq_data_i,
  output logic                          rf_wr_o,
  output logic [4:0]                    rf_addr_o,
  output logic [XLEN-1:0]               rf_data_o,
  output logic [$clog2(FIFO_DEPTH):0]   pend_cnt_o
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned StW  = $clog2(STARVE_LIMIT + 1);

  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [StW-1:0]  starve_q, starve_d;
  logic [4:0]      mem_addr_q [FIFO_DEPTH];
  logic [4:0]      mem_addr_d [FIFO_DEPTH];
  logic [XLEN-1:0] mem_data_q [FIFO_DEPTH];
  logic [XLEN-1:0] mem_data_d [FIFO_DEPTH];
  logic            rf_wr_q, rf_wr_d;
  logic [4:0]      rf_addr_q, rf_addr_d;
  logic [XLEN-1:0] rf_data_q, rf_data_d;

  logic            active, fifo_empty, fifo_full, starve_hit;
  logic            push, grant_fifo, grant_ex;
  logic [4:0]      head_addr;
  logic [XLEN-1:0] head_data;

  assign active     = clk_en_i & resetb_i;
  assign fifo_empty = (cnt_q == '0);
  assign fifo_full  = (cnt_q == CntW'(FIFO_DEPTH));
  assign starve_hit = (starve_q == StW'(STARVE_LIMIT));
  assign head_addr  = mem_addr_q[rd_ptr_q];
  assign head_data  = mem_data_q[rd_ptr_q];

  // Ready looks only at registered occupancy: a same-cycle pop never frees a slot.
  assign lsq_ready_o = ~fifo_full & active;
  assign push        = lsq_valid_i & lsq_ready_o;

  always_comb begin
    grant_fifo  = 1'b0;
    grant_ex    = 1'b0;
    exs_stall_o = 1'b0;
    if (active) begin
      if (starve_hit && !fifo_empty) begin
        grant_fifo  = 1'b1;
        exs_stall_o = exs_wr_i;
      end else if (exs_wr_i) begin
        grant_ex = 1'b1;
      end else if (!fifo_empty) begin
        grant_fifo = 1'b1;
      end
    end
  end

  // FIFO storage and pointers; pointers wrap naturally as depth is a power of 2.
  always_comb begin
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;
    if (push) begin
      mem_addr_d[wr_ptr_q] = lsq_addr_i;
      mem_data_d[wr_ptr_q] = lsq_data_i;
      wr_ptr_d             = wr_ptr_q + PtrW'(1);
    end
    if (grant_fifo) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    unique case ({push, grant_fifo})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Starve counter counts consecutive enabled cycles the non-empty FIFO is denied.
  always_comb begin
    starve_d = starve_q;
    if (active) begin
      if (fifo_empty || grant_fifo) begin
        starve_d = '0;
      end else if (!starve_hit) begin
        starve_d = starve_q + StW'(1);
      end
    end
  end

  // Output register: x0 writes are consumed but never assert the enable.
  always_comb begin
    rf_wr_d   = rf_wr_q;
    rf_addr_d = rf_addr_q;
    rf_data_d = rf_data_q;
    if (grant_fifo) begin
      rf_wr_d   = (head_addr != 5'd0);
      rf_addr_d = head_addr;
      rf_data_d = head_data;
    end else if (grant_ex) begin
      rf_wr_d   = (exs_addr_i != 5'd0);
      rf_addr_d = exs_addr_i;
      rf_data_d = exs_data_i;
    end else if (active) begin
      rf_wr_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!resetb_i) begin
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      cnt_q     <= '0;
      starve_q  <= '0;
      rf_wr_q   <= 1'b0;
      rf_addr_q <= '0;
      rf_data_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_addr_q[i] <= '0;
        mem_data_q[i] <= '0;
      end
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      cnt_q      <= cnt_d;
      starve_q   <= starve_d;
      rf_wr_q    <= rf_wr_d;
      rf_addr_q  <= rf_addr_d;
      rf_data_q  <= rf_data_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
    end
  end

  assign rf_wr_o    = rf_wr_q;
  assign rf_addr_o  = rf_addr_q;
  assign rf_data_o  = rf_data_q;
  assign pend_cnt_o = cnt_q;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
module tb_regfile_wr_arbiter;

  logic        clk_i = 1'b0;
  logic        resetb_i = 1'b0;
  logic        clk_en_i = 1'b1;
  logic        exs_wr_i = 1'b0;
  logic [4:0]  exs_addr_i = '0;
  logic [31:0] exs_data_i = '0;
  logic        exs_stall_o;
  logic        lsq_valid_i = 1'b0;
  logic        lsq_ready_o;
  logic [4:0]  lsq_addr_i = '0;
  logic [31:0] lsq_data_i = '0;
  logic        rf_wr_o;
  logic [4:0]  rf_addr_o;
  logic [31:0] rf_data_o;
  logic [1:0]  pend_cnt_o;

  int vectors = 0;
  int miscompares = 0;

  logic [36:0] sb [$];      // expected {addr, data} of each rf write, in order
  logic [4:0]  pend_q [$];  // nonzero destinations of loads still in flight
  logic        mon_en, mon_hit;
  logic [36:0] mon_exp;

  regfile_wr_arbiter dut (
    .clk_i      (clk_i),
    .resetb_i   (resetb_i),
    .clk_en_i   (clk_en_i),
    .exs_wr_i   (exs_wr_i),
    .exs_addr_i (exs_addr_i),
    .exs_data_i (exs_data_i),
    .exs_stall_o(exs_stall_o),
    .lsq_valid_i(lsq_valid_i),
    .lsq_ready_o(lsq_ready_o),
    .lsq_addr_i (lsq_addr_i),
    .lsq_data_i (lsq_data_i),
    .rf_wr_o    (rf_wr_o),
    .rf_addr_o  (rf_addr_o),
    .rf_data_o  (rf_data_o),
    .pend_cnt_o (pend_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard monitor: every write seen after an enabled edge must match the queue head.
  always @(posedge clk_i) begin
    mon_en = clk_en_i & resetb_i;
    if (!resetb_i) begin
      pend_q.delete();
    end else if (clk_en_i) begin
      mon_hit = 1'b0;
      if (exs_wr_i) begin
        for (int i = 0; i < pend_q.size(); i++) begin
          if (pend_q[i] == exs_addr_i) mon_hit = 1'b1;
        end
      end
      assert (!mon_hit) else $error("EX write targets register with pending load");
      if (lsq_valid_i && lsq_ready_o && lsq_addr_i != 5'd0) pend_q.push_back(lsq_addr_i);
    end
    #1;
    if (mon_en && rf_wr_o) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL sb_unexpected: got write x%0d=%h, expected no write", rf_addr_o, rf_data_o);
      end else begin
        mon_exp = sb.pop_front();
        if ({rf_addr_o, rf_data_o} !== mon_exp) begin
          miscompares++;
          $display("FAIL sb_write: got x%0d=%h, expected x%0d=%h",
                   rf_addr_o, rf_data_o, mon_exp[36:32], mon_exp[31:0]);
        end
      end
      if (pend_q.size() != 0 && pend_q[0] == rf_addr_o) void'(pend_q.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    exs_wr_i    = 1'b0;
    lsq_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    exs_wr_i = 1'b1; exs_addr_i = 5'd3; exs_data_i = 32'hA0;
    lsq_valid_i = 1'b1; lsq_addr_i = 5'd1; lsq_data_i = 32'h101;
    tick(); tick(); #1;
    vectors++;
    if (lsq_ready_o !== 1'b0 || exs_stall_o !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_comb: got ready=%b stall=%b, expected 0 0", lsq_ready_o, exs_stall_o);
    end
    vectors++;
    if (rf_wr_o !== 1'b0 || rf_addr_o !== 5'd0 || rf_data_o !== 32'd0 || pend_cnt_o !== 2'd0) begin
      miscompares++;
      $display("FAIL rst_vals: got wr=%b a=%0d d=%h pend=%0d, expected all 0",
               rf_wr_o, rf_addr_o, rf_data_o, pend_cnt_o);
    end
    // Fill the FIFO with two loads while EX keeps the port busy.
    resetb_i = 1'b1;
    sb.push_back({5'd3, 32'hA0});
    tick();
    lsq_addr_i = 5'd2; lsq_data_i = 32'h102;
    sb.push_back({5'd3, 32'hA0});
    tick();
    vectors++;
    if (pend_cnt_o !== 2'd2) begin
      miscompares++;
      $display("FAIL rst_fill: got pend=%0d, expected 2", pend_cnt_o);
    end
    lsq_valid_i = 1'b0;
    resetb_i = 1'b0;
    tick();
    vectors++;
    if (rf_wr_o !== 1'b0 || pend_cnt_o !== 2'd0 || rf_addr_o !== 5'd0) begin
      miscompares++;
      $display("FAIL rst_mid: got wr=%b pend=%0d a=%0d, expected 0 0 0",
               rf_wr_o, pend_cnt_o, rf_addr_o);
    end
    resetb_i = 1'b1;
    idle();
    #1;
    vectors++;
    if (lsq_ready_o !== 1'b1 || exs_stall_o !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_ready: got ready=%b stall=%b, expected 1 0", lsq_ready_o, exs_stall_o);
    end
    tick();
    vectors++;
    if (rf_wr_o !== 1'b0 || pend_cnt_o !== 2'd0) begin
      miscompares++;
      $display("FAIL rst_stale: got wr=%b pend=%0d, expected 0 0", rf_wr_o, pend_cnt_o);
    end
    #2;
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL rst_sb: got %0d outstanding writes, expected 0", sb.size());
    end
  endtask

  task automatic test_single_load();
    lsq_valid_i = 1'b1; lsq_addr_i = 5'd5; lsq_data_i = 32'hDEADBEEF;
    sb.push_back({5'd5, 32'hDEADBEEF});
    tick();
    lsq_valid_i = 1'b0;
    vectors++;
    if (pend_cnt_o !== 2'd1 || rf_wr_o !== 1'b0) begin
      miscompares++;
      $display("FAIL load_push: got pend=%0d wr=%b, expected 1 0", pend_cnt_o, rf_wr_o);
    end
    tick();
    vectors++;
    if (rf_wr_o !== 1'b1 || rf_addr_o !== 5'd5 || rf_data_o !== 32'hDEADBEEF || pend_cnt_o !== 2'd0) begin
      miscompares++;
      $display("FAIL load_write: got wr=%b a=%0d d=%h pend=%0d, expected 1 5 deadbeef 0",
               rf_wr_o, rf_addr_o, rf_data_o, pend_cnt_o);
    end
    #2;
  endtask

  task automatic test_priority();
    lsq_valid_i = 1'b1; lsq_addr_i = 5'd7; lsq_data_i = 32'h11;
    tick();
    lsq_valid_i = 1'b0;
    exs_wr_i = 1'b1; exs_addr_i = 5'd3; exs_data_i = 32'h22;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) begin
        exs_wr_i = 1'b0;
        sb.push_back({5'd7, 32'h11});
      end else begin
        sb.push_back({5'd3, 32'h22});
      end
      #1;
      vectors++;
      if (exs_stall_o !== 1'b0) begin
        miscompares++;
        $display("FAIL prio_stall%0d: got stall=%b, expected 0", i, exs_stall_o);
      end
      tick();
      vectors++;
      if (rf_wr_o !== 1'b1 || rf_addr_o !== ((i == 2) ? 5'd7 : 5'd3)) begin
        miscompares++;
        $display("FAIL prio_write%0d: got wr=%b a=%0d, expected 1 %0d",
                 i, rf_wr_o, rf_addr_o, (i == 2) ? 7 : 3);
      end
    end
    #2;
  endtask

  task automatic test_starvation();
    lsq_valid_i = 1'b1; lsq_addr_i = 5'd9; lsq_data_i = 32'h99;
    tick();
    lsq_valid_i = 1'b0;
    exs_wr_i = 1'b1; exs_addr_i = 5'd3;
    for (int i = 1; i <= 4; i++) begin
      exs_data_i = 32'h30 + i;
      sb.push_back({5'd3, 32'h30 + i});
      #1;
      vectors++;
      if (exs_stall_o !== 1'b0) begin
        miscompares++;
        $display("FAIL starve_nostall%0d: got stall=%b, expected 0", i, exs_stall_o);
      end
      tick();
    end
    exs_data_i = 32'h35;
    sb.push_back({5'd9, 32'h99});
    #1;
    vectors++;
    if (exs_stall_o !== 1'b1) begin
      miscompares++;
      $display("FAIL starve_stall: got stall=%b, expected 1", exs_stall_o);
    end
    tick();
    vectors++;
    if (rf_wr_o !== 1'b1 || rf_addr_o !== 5'd9 || rf_data_o !== 32'h99 || pend_cnt_o !== 2'd0) begin
      miscompares++;
      $display("FAIL starve_forced: got wr=%b a=%0d d=%h pend=%0d, expected 1 9 99 0",
               rf_wr_o, rf_addr_o, rf_data_o, pend_cnt_o);
    end
    sb.push_back({5'd3, 32'h35});
    #1;
    vectors++;
    if (exs_stall_o !== 1'b0) begin
      miscompares++;
      $display("FAIL starve_release: got stall=%b, expected 0", exs_stall_o);
    end
    tick();
    exs_wr_i = 1'b0;
    vectors++;
    if (rf_addr_o !== 5'd3 || rf_data_o !== 32'h35) begin
      miscompares++;
      $display("FAIL starve_held: got a=%0d d=%h, expected 3 35", rf_addr_o, rf_data_o);
    end
    #2;
  endtask

  task automatic test_full();
    exs_wr_i = 1'b1; exs_addr_i = 5'd3;
    lsq_valid_i = 1'b1;
    // Cycles 1..3: EX busy, loads x1, x2 accepted, x4 refused while full.
    for (int i = 1; i <= 3; i++) begin
      exs_data_i = 32'hC0 + i;
      lsq_addr_i = (i == 3) ? 5'd4 : 5'(i);
      lsq_data_i = 32'hA0 + ((i == 3) ? 4 : i);
      sb.push_back({5'd3, 32'hC0 + i});
      #1;
      vectors++;
      if (lsq_ready_o !== (i != 3)) begin
        miscompares++;
        $display("FAIL full_ready%0d: got ready=%b, expected %0d", i, lsq_ready_o, i != 3);
      end
      tick();
      vectors++;
      if (pend_cnt_o !== ((i == 1) ? 2'd1 : 2'd2)) begin
        miscompares++;
        $display("FAIL full_pend%0d: got pend=%0d, expected %0d", i, pend_cnt_o, (i == 1) ? 1 : 2);
      end
    end
    exs_wr_i = 1'b0;
    sb.push_back({5'd1, 32'hA1});
    #1;
    vectors++;
    if (lsq_ready_o !== 1'b0) begin
      miscompares++;
      $display("FAIL full_popready: got ready=%b, expected 0", lsq_ready_o);
    end
    tick();
    sb.push_back({5'd2, 32'hA2});
    #1;
    vectors++;
    if (lsq_ready_o !== 1'b1) begin
      miscompares++;
      $display("FAIL full_reopen: got ready=%b, expected 1", lsq_ready_o);
    end
    tick();
    lsq_valid_i = 1'b0;
    vectors++;
    if (pend_cnt_o !== 2'd1) begin
      miscompares++;
      $display("FAIL full_pushpop: got pend=%0d, expected 1", pend_cnt_o);
    end
    sb.push_back({5'd4, 32'hA4});
    tick();
    vectors++;
    if (pend_cnt_o !== 2'd0 || rf_addr_o !== 5'd4) begin
      miscompares++;
      $display("FAIL full_drain: got pend=%0d a=%0d, expected 0 4", pend_cnt_o, rf_addr_o);
    end
    #2;
  endtask

  task automatic test_x0_clken();
    lsq_valid_i = 1'b1; lsq_addr_i = 5'd0; lsq_data_i = 32'h55;
    tick();
    lsq_valid_i = 1'b0;
    tick();
    vectors++;
    if (rf_wr_o !== 1'b0 || pend_cnt_o !== 2'd0 || rf_addr_o !== 5'd0 || rf_data_o !== 32'h55) begin
      miscompares++;
      $display("FAIL x0_pop: got wr=%b pend=%0d a=%0d d=%h, expected 0 0 0 55",
               rf_wr_o, pend_cnt_o, rf_addr_o, rf_data_o);
    end
    lsq_valid_i = 1'b1; lsq_addr_i = 5'd6; lsq_data_i = 32'h66;
    tick();
    lsq_valid_i = 1'b0;
    exs_wr_i = 1'b1; exs_addr_i = 5'd8; exs_data_i = 32'h88;
    sb.push_back({5'd8, 32'h88});
    tick();
    clk_en_i = 1'b0;
    exs_data_i = 32'h89;
    lsq_valid_i = 1'b1; lsq_addr_i = 5'd10; lsq_data_i = 32'hAA;
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++;
      if (lsq_ready_o !== 1'b0 || exs_stall_o !== 1'b0) begin
        miscompares++;
        $display("FAIL cken_comb%0d: got ready=%b stall=%b, expected 0 0", i, lsq_ready_o, exs_stall_o);
      end
      tick();
      vectors++;
      if (rf_wr_o !== 1'b1 || rf_addr_o !== 5'd8 || rf_data_o !== 32'h88 || pend_cnt_o !== 2'd1) begin
        miscompares++;
        $display("FAIL cken_hold%0d: got wr=%b a=%0d d=%h pend=%0d, expected 1 8 88 1",
                 i, rf_wr_o, rf_addr_o, rf_data_o, pend_cnt_o);
      end
    end
    clk_en_i = 1'b1;
    idle();
    sb.push_back({5'd6, 32'h66});
    #1;
    vectors++;
    if (lsq_ready_o !== 1'b1) begin
      miscompares++;
      $display("FAIL cken_ready: got ready=%b, expected 1", lsq_ready_o);
    end
    tick();
    vectors++;
    if (rf_addr_o !== 5'd6 || pend_cnt_o !== 2'd0) begin
      miscompares++;
      $display("FAIL cken_resume: got a=%0d pend=%0d, expected 6 0", rf_addr_o, pend_cnt_o);
    end
    #2;
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL final_sb: got %0d outstanding writes, expected 0", sb.size());
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_single_load();
    test_priority();
    test_starvation();
    test_full();
    test_x0_clken();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
